// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with forwarding flags, load-use interlock and stallable/flushable ID/EX register
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instr_valid,
    input  logic            stall_in,
    input  logic            flush,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic [11:0]     operation,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            rs1_fwd,
    output logic            rs2_fwd,
    output logic [XLEN-1:0] pc,
    output logic            isBranch,
    output logic            valid_out,
    output logic            stall_out,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    // writes/load travel with the instruction so hazards are judged against what execute holds
    typedef struct packed {
        logic [11:0]     op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            fwd1;
        logic            fwd2;
        logic [XLEN-1:0] pc;
        logic            branch;
        logic            valid;
        logic            writes;
        logic            load;
    } idex_t;

    idex_t          idex_q;
    idex_t          decoded;
    idex_t          bubble;
    logic [CW-1:0]  flush_cnt;
    logic           illegal_q;

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [4:0]     rd_field;
    logic [31:0]    imm32;
    logic [1:0]     op_hi;
    logic           legal;
    logic           is_load;
    logic           is_branch;
    logic           writes_rd;
    logic           in_flush;
    logic           interlock;
    logic           issue;

    assign opcode      = instr_in[6:0];
    assign funct3      = instr_in[14:12];
    assign rd_field    = instr_in[11:7];
    assign rf_rs1_addr = instr_in[19:15];
    assign rf_rs2_addr = instr_in[24:20];

    always_comb begin
        legal     = 1'b1;
        is_load   = 1'b0;
        is_branch = 1'b0;
        writes_rd = 1'b1;
        imm32     = '0;
        op_hi     = 2'b00;
        case (opcode)
            OPC_OP: begin
                op_hi = {instr_in[30], instr_in[25]};
            end
            OPC_OP_IMM: begin
                imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
                if (funct3 == 3'b101) op_hi = {instr_in[30], instr_in[25]};
            end
            OPC_LOAD: begin
                imm32   = {{20{instr_in[31]}}, instr_in[31:20]};
                is_load = 1'b1;
            end
            OPC_JALR: begin
                imm32     = {{20{instr_in[31]}}, instr_in[31:20]};
                is_branch = 1'b1;
            end
            OPC_STORE: begin
                imm32     = {{21{instr_in[31]}}, instr_in[30:25], instr_in[11:7]};
                writes_rd = 1'b0;
            end
            OPC_BRANCH: begin
                imm32     = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
                is_branch = 1'b1;
                writes_rd = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {instr_in[31:12], 12'b0};
            end
            OPC_JAL: begin
                imm32     = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
                is_branch = 1'b1;
            end
            default: begin
                legal     = 1'b0;
                writes_rd = 1'b0;
            end
        endcase
        if (rd_field == 5'd0) writes_rd = 1'b0;
    end

    always_comb begin
        in_flush  = flush || (flush_cnt != '0);
        interlock = idex_q.load && instr_valid && (idex_q.rd != 5'd0) &&
                    ((rf_rs1_addr == idex_q.rd) || (rf_rs2_addr == idex_q.rd));
        issue     = !in_flush && !stall_in && !interlock && instr_valid && legal;
        stall_out = !in_flush && (interlock || stall_in);
    end

    always_comb begin
        bubble    = '0;
        bubble.op = 12'h013;

        decoded        = '0;
        decoded.op     = {op_hi, funct3, opcode};
        decoded.rs1    = rf_rs1_data;
        decoded.rs2    = rf_rs2_data;
        decoded.imm    = XLEN'($signed(imm32));
        decoded.rd     = rd_field;
        decoded.fwd1   = issue && idex_q.writes && (rf_rs1_addr == idex_q.rd);
        decoded.fwd2   = issue && idex_q.writes && (rf_rs2_addr == idex_q.rd);
        decoded.pc     = pc_in;
        decoded.branch = is_branch;
        decoded.valid  = 1'b1;
        decoded.writes = writes_rd;
        decoded.load   = is_load;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q    <= bubble;
            flush_cnt <= '0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            idex_q    <= bubble;
            flush_cnt <= CW'(FLUSH_DEPTH - 1);
            illegal_q <= 1'b0;
        end else if (flush_cnt != '0) begin
            idex_q    <= bubble;
            flush_cnt <= flush_cnt - CW'(1);
            illegal_q <= 1'b0;
        end else if (stall_in) begin
            illegal_q <= 1'b0;
        end else if (issue) begin
            idex_q    <= decoded;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= bubble;
            illegal_q <= instr_valid && !interlock && !legal;
        end
    end

    assign operation = idex_q.op;
    assign rs1       = idex_q.rs1;
    assign rs2       = idex_q.rs2;
    assign imm       = idex_q.imm;
    assign rd        = idex_q.rd;
    assign rs1_fwd   = idex_q.fwd1;
    assign rs2_fwd   = idex_q.fwd2;
    assign pc        = idex_q.pc;
    assign isBranch  = idex_q.branch;
    assign valid_out = idex_q.valid;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        stall_in;
    logic        flush;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic [11:0] operation;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] pc;
    logic        is_branch;
    logic        valid_out;
    logic        stall_out;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rf_rs1_data = 32'h1000_0000 | {27'd0, rf_rs1_addr};
    assign rf_rs2_data = 32'h2000_0000 | {27'd0, rf_rs2_addr};

    decode_stage #(.XLEN(32), .FLUSH_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .instr_valid (instr_valid),
        .stall_in    (stall_in),
        .flush       (flush),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .operation   (operation),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .rd          (rd),
        .rs1_fwd     (rs1_fwd),
        .rs2_fwd     (rs2_fwd),
        .pc          (pc),
        .isBranch    (is_branch),
        .valid_out   (valid_out),
        .stall_out   (stall_out),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // apply inputs just after an edge, then let combinational outputs settle
    task automatic drive(input logic [31:0] ins, input logic [31:0] p, input logic v,
                         input logic st, input logic fl);
        instr_in    = ins;
        pc_in       = p;
        instr_valid = v;
        stall_in    = st;
        flush       = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_in = '0; pc_in = '0; instr_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        tick(); tick();
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_op", {20'd0, operation}, 32'h013);
        check("reset_illegal", {31'd0, illegal}, 32'd0);

        // async reset mid-stream
        rst_n = 1'b1;
        drive(32'h0070_0293, 32'h100, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_reset_valid", {31'd0, valid_out}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, valid_out}, 32'd0);
        check("async_imm", imm, 32'd0);
        check("async_op", {20'd0, operation}, 32'h013);
        rst_n = 1'b1;
        tick();

        // ADDI x5,x0,7
        check("addi_op", {20'd0, operation}, 32'h013);
        check("addi_imm", imm, 32'd7);
        check("addi_rd", {27'd0, rd}, 32'd5);
        check("addi_valid", {31'd0, valid_out}, 32'd1);
        check("addi_fwd1", {31'd0, rs1_fwd}, 32'd0);
        check("addi_pc", pc, 32'h100);
        check("addi_rs1", rs1, 32'h1000_0000);

        // SW x5,-4(x2)
        drive(32'hFE51_2E23, 32'h104, 1'b1, 1'b0, 1'b0);
        tick();
        check("sw_imm", imm, 32'hFFFF_FFFC);
        check("sw_op", {20'd0, operation}, 32'h123);
        check("sw_fwd2", {31'd0, rs2_fwd}, 32'd1);
        check("sw_fwd1", {31'd0, rs1_fwd}, 32'd0);
        check("sw_rs2", rs2, 32'h2000_0005);

        // BEQ x1,x2,-8
        drive(32'hFE20_8CE3, 32'h108, 1'b1, 1'b0, 1'b0);
        tick();
        check("beq_imm", imm, 32'hFFFF_FFF8);
        check("beq_branch", {31'd0, is_branch}, 32'd1);
        check("beq_op", {20'd0, operation}, 32'h063);

        // flush with stall_in also high, FLUSH_DEPTH=2
        drive(32'h0070_0293, 32'h10C, 1'b1, 1'b1, 1'b1);
        check("flush_stall_out", {31'd0, stall_out}, 32'd0);
        tick();
        check("flush_b1_valid", {31'd0, valid_out}, 32'd0);
        check("flush_b1_branch", {31'd0, is_branch}, 32'd0);
        drive(32'h0070_0293, 32'h200, 1'b1, 1'b1, 1'b0);
        check("flush_cnt_stall_out", {31'd0, stall_out}, 32'd0);
        tick();
        check("flush_b2_valid", {31'd0, valid_out}, 32'd0);
        check("flush_b2_op", {20'd0, operation}, 32'h013);
        drive(32'h0070_0293, 32'h200, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_flush_valid", {31'd0, valid_out}, 32'd1);

        // LW x6,0(x1) then ADD x7,x6,x6
        drive(32'h0000_A303, 32'h204, 1'b1, 1'b0, 1'b0);
        tick();
        check("lw_op", {20'd0, operation}, 32'h103);
        check("lw_rd", {27'd0, rd}, 32'd6);
        drive(32'h0063_03B3, 32'h208, 1'b1, 1'b0, 1'b0);
        check("lu_stall_out", {31'd0, stall_out}, 32'd1);
        tick();
        check("lu_bubble_valid", {31'd0, valid_out}, 32'd0);
        #1;
        check("lu_release_stall", {31'd0, stall_out}, 32'd0);
        tick();
        check("add_op", {20'd0, operation}, 32'h033);
        check("add_fwd1", {31'd0, rs1_fwd}, 32'd0);
        check("add_fwd2", {31'd0, rs2_fwd}, 32'd0);
        check("add_rs1", rs1, 32'h1000_0006);
        check("add_valid", {31'd0, valid_out}, 32'd1);
        check("add_rd", {27'd0, rd}, 32'd7);

        // x0 hazard: ADDI x0,x0,1 then ADD x3,x0,x0
        drive(32'h0010_0013, 32'h20C, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0000_01B3, 32'h210, 1'b1, 1'b0, 1'b0);
        tick();
        check("x0_fwd1", {31'd0, rs1_fwd}, 32'd0);
        check("x0_fwd2", {31'd0, rs2_fwd}, 32'd0);
        check("x0_valid", {31'd0, valid_out}, 32'd1);

        // illegal opcode
        drive(32'hFFFF_FFFF, 32'h214, 1'b1, 1'b0, 1'b0);
        check("ill_stall_out", {31'd0, stall_out}, 32'd0);
        tick();
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_valid", {31'd0, valid_out}, 32'd0);
        check("ill_op", {20'd0, operation}, 32'h013);
        drive(32'h0070_0293, 32'h300, 1'b1, 1'b0, 1'b0);
        tick();
        check("ill_clear", {31'd0, illegal}, 32'd0);
        check("ill_next_pc", pc, 32'h300);

        // stall_in holds ID/EX
        drive(32'hFE51_2E23, 32'h304, 1'b1, 1'b1, 1'b0);
        check("stall_out_hold", {31'd0, stall_out}, 32'd1);
        tick();
        check("hold_pc", pc, 32'h300);
        check("hold_imm", imm, 32'd7);
        check("hold_op", {20'd0, operation}, 32'h013);
        check("hold_valid", {31'd0, valid_out}, 32'd1);

        // ADDI x6,x5,1 forwards from held ADDI x5
        drive(32'h0012_8313, 32'h308, 1'b1, 1'b0, 1'b0);
        tick();
        check("fwd1_hit", {31'd0, rs1_fwd}, 32'd1);
        check("fwd1_imm", imm, 32'd1);
        check("fwd1_fwd2", {31'd0, rs2_fwd}, 32'd0);

        // SUB x1,x2,x3
        drive(32'h4031_00B3, 32'h30C, 1'b1, 1'b0, 1'b0);
        tick();
        check("sub_op", {20'd0, operation}, 32'h833);
        check("sub_imm", imm, 32'd0);

        // LUI x4,0x12345
        drive(32'h1234_5237, 32'h310, 1'b1, 1'b0, 1'b0);
        tick();
        check("lui_imm", imm, 32'h1234_5000);
        check("lui_op", {20'd0, operation}, 32'h2B7);

        // invalid input gives a bubble without illegal
        drive(32'hFFFF_FFFF, 32'h314, 1'b0, 1'b0, 1'b0);
        tick();
        check("idle_valid", {31'd0, valid_out}, 32'd0);
        check("idle_illegal", {31'd0, illegal}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
